display_capture: RTL and testbench
==================================

DISPLAY_CAPTURE -- requirements
Module: display_capture

Interface
REQ-001 STABLE_CYCLES, 16, consecutive identical synchronized samples needed to accept a digit (legal range >= 2).
REQ-002 TIMEOUT_CYCLES, 2000000, cycles since last publish before a forced publish (legal range > STABLE_CYCLES + 4).
REQ-003 clk  input  1  system clock, 100 MHz, the only clock.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 a, b, c, d, e, f, g, dp  input  1 each  segment lines, active-low.
REQ-006 an_0, an_1, an_2, an_3  input  1 each  anode lines, active-low; an_0 = rightmost position.
REQ-007 digit_3, digit_2, digit_1, digit_0  output  4 each  decoded value per position, 0-9.
REQ-008 blank  output  4  bit i set = position i dark or not seen in the published frame.
REQ-009 dp_on  output  4  bit i = decimal point lit at position i.
REQ-010 code_err  output  4  bit i = position i showed an undecodable lit pattern.
REQ-011 frame_strobe  output  1  one-cycle pulse when outputs are updated.
REQ-012 frame_valid  output  1  published frame holds at least one seen position.

Function
REQ-013 The block SHALL pass all 12 display inputs through a 2-flop synchronizer; W = synchronized {an_3..an_0, dp, g..a}.
REQ-014 Position i SHALL be selected only when an_i = 0 and the other three anodes = 1; any other anode combination is no selection.
REQ-015 A stability counter SHALL clear when W differs from the previous cycle's W and increment (saturating) otherwise.
REQ-016 FSM states: WAIT (no selection), SETTLE (selection, counter < STABLE_CYCLES-1), HELD (accepted); any change of W returns to SETTLE or WAIT; no selection returns to WAIT.
REQ-017 Accept SHALL occur exactly once per run: on the SETTLE->HELD transition when W has been held STABLE_CYCLES consecutive cycles.
REQ-018 Decode, lit segments -> value: 0=abcdef, 1=bc, 2=abdeg, 3=abcdg, 4=bcfg, 5=acdfg, 6=acdefg, 7=abc, 8=abcdefg, 9=abcdfg; dp decoded independently.
REQ-019 No segment a-g lit SHALL record blank=1, digit=0, code_err=0; any other non-table pattern records digit=0, blank=0, code_err=1.
REQ-020 Accept SHALL write the position's shadow slot and set its seen bit; a repeat accept of the same position before publish overwrites the slot.
REQ-021 When seen becomes 1111, the next cycle SHALL copy shadow to outputs, pulse frame_strobe, set frame_valid=1, clear seen and the timeout counter.
REQ-022 The timeout counter SHALL increment every non-publish cycle; on reaching TIMEOUT_CYCLES-1 a forced publish occurs: seen slots from shadow, unseen slots digit=0, blank=1, dp_on=0, code_err=0.
REQ-023 Forced publish SHALL pulse frame_strobe and set frame_valid = (seen != 0), then clear seen.
REQ-024 Complete-mask publish and timeout in the same cycle SHALL produce one complete-mask publish (frame_valid=1).
REQ-025 An accept in the publish cycle SHALL belong to the next frame (seen bit set after the clear).
REQ-026 Latency from last digit's inputs settling to frame_strobe SHALL be 2 + STABLE_CYCLES + 1 cycles.
REQ-027 Outputs other than frame_strobe SHALL hold between publishes.

Reset
REQ-028 On rst: digits=0, blank=1111, dp_on=0, code_err=0, frame_strobe=0, frame_valid=0.
REQ-029 On rst: seen=0, both counters=0, FSM=WAIT, synchronizer flops=1 (all lines inactive).
REQ-030 Reset mid-frame SHALL discard the partial shadow; no strobe until a fresh full frame or timeout after reset.

Verification
REQ-031 Scan "1","2","3","4" on an_3..an_0, each held 40 cycles -> one strobe, digit_3..0=1,2,3,4, blank=0000, frame_valid=1.
REQ-032 Position held 10 cycles then changed (STABLE_CYCLES=16) -> no accept, seen unchanged.
REQ-033 an_2 and an_1 both low with "8" for 100 cycles -> no accept; only positions 3,0 driven -> forced publish after TIMEOUT_CYCLES, blank=0110, frame_valid=1.
REQ-034 No anode low for TIMEOUT_CYCLES -> strobe, blank=1111, frame_valid=0.
REQ-035 Pattern abcefg on an_0 -> code_err=0001, digit_0=0; dp low on an_1 -> dp_on=0010.
REQ-036 rst after three positions accepted, then a full scan -> first strobe reflects only the post-reset scan; outputs equal REQ-028 values until then.

Source files
------------

// File: rtl/display_capture.sv
// Captures the four digits of a multiplexed, active-low 7-segment display.
// Display lines are synchronized, each anode selection must stay stable for
// STABLE_CYCLES before its segments are decoded into a shadow frame. A frame
// is published when all four positions have been seen, or when TIMEOUT_CYCLES
// pass without a publish (unseen positions then read as blank).
module display_capture #(
  parameter int STABLE_CYCLES  = 16,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       a,
  input  logic       b,
  input  logic       c,
  input  logic       d,
  input  logic       e,
  input  logic       f,
  input  logic       g,
  input  logic       dp,
  input  logic       an_0,
  input  logic       an_1,
  input  logic       an_2,
  input  logic       an_3,
  output logic [3:0] digit_3,
  output logic [3:0] digit_2,
  output logic [3:0] digit_1,
  output logic [3:0] digit_0,
  output logic [3:0] blank,
  output logic [3:0] dp_on,
  output logic [3:0] code_err,
  output logic       frame_strobe,
  output logic       frame_valid
);

  localparam int SCW = $clog2(STABLE_CYCLES);
  localparam int TCW = $clog2(TIMEOUT_CYCLES);
  localparam logic [SCW-1:0] STABLE_LAST  = SCW'(STABLE_CYCLES - 1);
  localparam logic [TCW-1:0] TIMEOUT_LAST = TCW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_WAIT,
    ST_SETTLE,
    ST_HELD
  } state_t;

  // W layout: {an_3..an_0, dp, g, f, e, d, c, b, a}
  logic [11:0]    raw;
  logic [11:0]    sync_1;
  logic [11:0]    w;
  logic [11:0]    w_prev;
  logic           same;
  logic           sel_valid;
  logic [1:0]     sel_idx;
  logic [SCW-1:0] stab_cnt;
  logic [SCW-1:0] cnt_now;
  state_t         state;
  state_t         state_next;
  logic           accept;
  logic [6:0]     lit;
  logic [3:0]     dec_digit;
  logic           dec_blank;
  logic           dec_err;
  logic [3:0]     sh_digit [4];
  logic [3:0]     sh_blank;
  logic [3:0]     sh_dp;
  logic [3:0]     sh_err;
  logic [3:0]     seen;
  logic [TCW-1:0] to_cnt;
  logic           publish;
  logic [3:0]     out_digit [4];

  assign raw  = {an_3, an_2, an_1, an_0, dp, g, f, e, d, c, b, a};
  assign same = (w == w_prev);

  // Two-flop synchronizer plus one cycle of history for change detection.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments let every flop sample the old value of
    // its source, so the chain shifts by exactly one stage per clock.
    if (rst) begin
      sync_1 <= '1;
      w      <= '1;
      w_prev <= '1;
    end else begin
      sync_1 <= raw;
      w      <= sync_1;
      w_prev <= w;
    end
  end

  // Exactly one anode low selects a position; anything else is no selection.
  always_comb begin
    // NOTE: defaults first so every path assigns every output and no latch
    // is inferred for the unlisted anode combinations.
    sel_valid = 1'b0;
    sel_idx   = 2'd0;
    case (w[11:8])
      4'b1110: begin sel_valid = 1'b1; sel_idx = 2'd0; end
      4'b1101: begin sel_valid = 1'b1; sel_idx = 2'd1; end
      4'b1011: begin sel_valid = 1'b1; sel_idx = 2'd2; end
      4'b0111: begin sel_valid = 1'b1; sel_idx = 2'd3; end
      default: ;
    endcase
  end

  // Run length of the current W minus one, saturating at the accept point.
  always_comb begin
    cnt_now = '0;
    if (same) begin
      cnt_now = (stab_cnt == STABLE_LAST) ? stab_cnt : stab_cnt + SCW'(1);
    end
  end

  // Stability counter and FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      stab_cnt <= '0;
      state    <= ST_WAIT;
    end else begin
      stab_cnt <= cnt_now;
      state    <= state_next;
    end
  end

  // Next-state logic; accept fires only on the SETTLE->HELD transition.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    if (!sel_valid) begin
      state_next = ST_WAIT;
    end else if (!same) begin
      state_next = ST_SETTLE;
    end else begin
      case (state)
        ST_SETTLE: begin
          if (cnt_now == STABLE_LAST) begin
            state_next = ST_HELD;
            accept     = 1'b1;
          end
        end
        ST_HELD: state_next = ST_HELD;
        default: state_next = ST_SETTLE;
      endcase
    end
  end

  // Segment decode of the lit pattern (bit 0 = a ... bit 6 = g).
  always_comb begin
    lit       = ~w[6:0];
    dec_digit = 4'd0;
    dec_blank = 1'b0;
    dec_err   = 1'b0;
    case (lit)
      7'h3F: dec_digit = 4'd0;
      7'h06: dec_digit = 4'd1;
      7'h5B: dec_digit = 4'd2;
      7'h4F: dec_digit = 4'd3;
      7'h66: dec_digit = 4'd4;
      7'h6D: dec_digit = 4'd5;
      7'h7D: dec_digit = 4'd6;
      7'h07: dec_digit = 4'd7;
      7'h7F: dec_digit = 4'd8;
      7'h6F: dec_digit = 4'd9;
      7'h00: dec_blank = 1'b1;
      default: dec_err = 1'b1;
    endcase
  end

  // Shadow frame slots written on accept.
  always_ff @(posedge clk) begin
    // NOTE: the shadow slots are not reset; a slot is only ever read when its
    // seen bit is set, and seen is cleared by reset.
    if (accept) begin
      sh_digit[sel_idx] <= dec_digit;
      sh_blank[sel_idx] <= dec_blank;
      sh_dp[sel_idx]    <= ~w[7];
      sh_err[sel_idx]   <= dec_err;
    end
  end

  // A full mask and a timeout in the same cycle collapse into one publish;
  // the seen mask decides which slots come from the shadow either way.
  assign publish = (seen == 4'hF) || (to_cnt == TIMEOUT_LAST);

  // Seen mask and timeout counter; an accept during publish starts the next frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      seen   <= '0;
      to_cnt <= '0;
    end else begin
      seen   <= (publish ? 4'h0 : seen) | (accept ? (4'b0001 << sel_idx) : 4'h0);
      to_cnt <= publish ? '0 : to_cnt + TCW'(1);
    end
  end

  // Published output registers, held between publishes.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) out_digit[i] <= '0;
      blank        <= 4'hF;
      dp_on        <= '0;
      code_err     <= '0;
      frame_strobe <= 1'b0;
      frame_valid  <= 1'b0;
    end else begin
      frame_strobe <= publish;
      if (publish) begin
        for (int i = 0; i < 4; i++) out_digit[i] <= seen[i] ? sh_digit[i] : 4'd0;
        blank       <= sh_blank | ~seen;
        dp_on       <= sh_dp & seen;
        code_err    <= sh_err & seen;
        frame_valid <= |seen;
      end
    end
  end

  assign digit_0 = out_digit[0];
  assign digit_1 = out_digit[1];
  assign digit_2 = out_digit[2];
  assign digit_3 = out_digit[3];

endmodule

// File: tb/tb_display_capture.sv
// Self-checking bench for display_capture: table-driven full scans plus
// hand-written sequences, with a queue of expected published frames that is
// popped on every frame_strobe.
module tb_display_capture;

  localparam int ST = 16;
  localparam int TO = 1000;
  localparam int HOLD = 40;

  typedef struct packed {
    logic [15:0] dig;
    logic [3:0]  blank;
    logic [3:0]  dp;
    logic [3:0]  err;
    logic        valid;
  } frame_t;

  typedef struct packed {
    logic [3:0][6:0] lit;
    logic [3:0]      dpl;
    frame_t          exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic a, b, c, d, e, f, g, dp;
  logic an_0, an_1, an_2, an_3;
  logic [3:0] digit_3, digit_2, digit_1, digit_0;
  logic [3:0] blank, dp_on, code_err;
  logic frame_strobe, frame_valid;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int strobe_cnt = 0;
  int last_strobe_cyc = 0;
  frame_t exp_q[$];
  vec_t vecs[3];

  display_capture #(.STABLE_CYCLES(ST), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g), .dp(dp),
    .an_0(an_0), .an_1(an_1), .an_2(an_2), .an_3(an_3),
    .digit_3(digit_3), .digit_2(digit_2), .digit_1(digit_1), .digit_0(digit_0),
    .blank(blank), .dp_on(dp_on), .code_err(code_err),
    .frame_strobe(frame_strobe), .frame_valid(frame_valid)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: every strobe must match the oldest expected frame.
  always @(negedge clk) begin
    frame_t ef;
    if (!rst && frame_strobe) begin
      strobe_cnt++;
      last_strobe_cyc = cyc;
      if (exp_q.size() == 0) begin
        check("unexpected_strobe", 1, 0);
      end else begin
        ef = exp_q.pop_front();
        check("digits", {digit_3, digit_2, digit_1, digit_0}, ef.dig);
        check("blank", blank, ef.blank);
        check("dp_on", dp_on, ef.dp);
        check("code_err", code_err, ef.err);
        check("frame_valid", frame_valid, ef.valid);
      end
    end
  end

  function automatic logic [6:0] seg(input int v);
    case (v)
      0: return 7'h3F;
      1: return 7'h06;
      2: return 7'h5B;
      3: return 7'h4F;
      4: return 7'h66;
      5: return 7'h6D;
      6: return 7'h7D;
      7: return 7'h07;
      8: return 7'h7F;
      9: return 7'h6F;
      default: return 7'h00;
    endcase
  endfunction

  task automatic drive(input logic [3:0] an, input logic [6:0] lit, input logic dpl);
    {an_3, an_2, an_1, an_0} = an;
    {g, f, e, d, c, b, a} = ~lit;
    dp = ~dpl;
  endtask

  task automatic idle();
    drive(4'hF, 7'h00, 1'b0);
  endtask

  task automatic hold(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic show(input int pos, input logic [6:0] lit, input logic dpl, input int n);
    drive(~(4'b0001 << pos), lit, dpl);
    hold(n);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_digits"}, {digit_3, digit_2, digit_1, digit_0}, 16'h0000);
    check({tag, "_blank"}, blank, 4'hF);
    check({tag, "_dp_on"}, dp_on, 4'h0);
    check({tag, "_code_err"}, code_err, 4'h0);
    check({tag, "_strobe"}, frame_strobe, 1'b0);
    check({tag, "_valid"}, frame_valid, 1'b0);
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    hold(3);
    rst = 1'b0;
  endtask

  // Scan positions 3..0, returning the cycle at which position 0 was driven.
  task automatic scan(input logic [3:0][6:0] lit, input logic [3:0] dpl, output int t0);
    t0 = 0;
    for (int p = 3; p >= 0; p--) begin
      if (p == 0) t0 = cyc;
      show(p, lit[p], dpl[p], HOLD);
    end
    idle();
  endtask

  task automatic wait_strobes(input int target, input int budget);
    int n = 0;
    while (strobe_cnt < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("strobe_arrived", strobe_cnt >= target, 1);
  endtask

  initial begin
    int t0;
    int t1;
    int base;
    frame_t ef;

    vecs[0].lit = {seg(1), seg(2), seg(3), seg(4)};
    vecs[0].dpl = 4'b0000;
    vecs[0].exp = '{dig: 16'h1234, blank: 4'h0, dp: 4'h0, err: 4'h0, valid: 1'b1};
    vecs[1].lit = {seg(5), seg(6), seg(7), seg(8)};
    vecs[1].dpl = 4'b0010;
    vecs[1].exp = '{dig: 16'h5678, blank: 4'h0, dp: 4'b0010, err: 4'h0, valid: 1'b1};
    vecs[2].lit = {seg(9), seg(0), 7'h00, 7'h77};
    vecs[2].dpl = 4'b0000;
    vecs[2].exp = '{dig: 16'h9000, blank: 4'b0010, dp: 4'h0, err: 4'b0001, valid: 1'b1};

    idle();
    do_reset();
    check_reset_outputs("reset");

    // Table-driven full scans, each with an exact latency check.
    for (int i = 0; i < 3; i++) begin
      do_reset();
      base = strobe_cnt;
      exp_q.push_back(vecs[i].exp);
      scan(vecs[i].lit, vecs[i].dpl, t0);
      wait_strobes(base + 1, 200);
      check("latency", last_strobe_cyc - t0, 2 + ST + 1);
    end

    // Short hold never accepts; repeat accept overwrites; timeout publishes.
    do_reset();
    base = strobe_cnt;
    exp_q.push_back('{dig: 16'h9067, blank: 4'b0100, dp: 4'h0, err: 4'h0, valid: 1'b1});
    show(2, seg(5), 1'b0, 10);
    show(1, seg(6), 1'b0, HOLD);
    show(0, seg(7), 1'b0, HOLD);
    show(3, seg(1), 1'b0, HOLD);
    idle();
    hold(5);
    show(3, seg(9), 1'b0, HOLD);
    idle();
    wait_strobes(base + 1, TO + 200);

    // Two anodes low is no selection; only positions 3 and 0 get published.
    do_reset();
    base = strobe_cnt;
    exp_q.push_back('{dig: 16'h3007, blank: 4'b0110, dp: 4'h0, err: 4'h0, valid: 1'b1});
    drive(4'b1001, seg(8), 1'b0);
    hold(100);
    show(3, seg(3), 1'b0, HOLD);
    show(0, seg(7), 1'b0, HOLD);
    idle();
    wait_strobes(base + 1, TO + 200);

    // Full frame, outputs hold, then an idle timeout publishes an empty frame.
    do_reset();
    base = strobe_cnt;
    exp_q.push_back(vecs[0].exp);
    scan(vecs[0].lit, vecs[0].dpl, t0);
    wait_strobes(base + 1, 200);
    t1 = last_strobe_cyc;
    exp_q.push_back('{dig: 16'h0000, blank: 4'hF, dp: 4'h0, err: 4'h0, valid: 1'b0});
    hold(100);
    check("hold_digits", {digit_3, digit_2, digit_1, digit_0}, 16'h1234);
    check("hold_valid", frame_valid, 1'b1);
    check("hold_strobe", frame_strobe, 1'b0);
    wait_strobes(base + 2, TO + 50);
    check("timeout_interval", last_strobe_cyc - t1, TO);

    // Reset mid-frame discards the partial frame.
    do_reset();
    base = strobe_cnt;
    show(3, seg(9), 1'b0, HOLD);
    show(2, seg(8), 1'b0, HOLD);
    show(1, seg(7), 1'b0, HOLD);
    idle();
    do_reset();
    check_reset_outputs("midreset");
    exp_q.push_back(vecs[1].exp);
    show(3, seg(5), 1'b0, HOLD);
    show(2, seg(6), 1'b0, HOLD);
    show(1, seg(7), 1'b1, HOLD);
    check_reset_outputs("pre_last");
    check("no_early_strobe", strobe_cnt, base);
    show(0, seg(8), 1'b0, HOLD);
    idle();
    wait_strobes(base + 1, 200);
    check("one_strobe", strobe_cnt, base + 1);

    hold(5);
    check("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
